key_scan_ctrl: RTL
==================

Name: key_scan_ctrl

Overview:
Sequencer for the 5-to-32 key-select decoder in the piano front end. It steps a 5-bit row select and enable through all 32 keys. For each key it waits for the line to settle, then samples the shared sense line and debounces each key independently. Each debounced press or release is reported as an event over a valid/ready handshake to the note logic downstream.

Parameters:
SETTLE_CYCLES, 4, cycles the select is held before sampling; legal range 3..15, because it must cover the 2-flop synchronizer latency.
DEBOUNCE_SCANS, 3, consecutive disagreeing samples needed to flip a key's state; legal range 1..7.

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
scan_en  in  1  allows scanning to start and continue
key_in  in  1  shared sense line, asynchronous, 1 = selected key pressed
row_sel  out  5  key index, drives the decoder select input
row_en  out  1  drives the decoder enable
key_state  out  32  debounced state of every key, 1 = pressed
evt_valid  out  1  event available
evt_key  out  5  index of the key that changed
evt_press  out  1  1 = press, 0 = release
evt_ready  in  1  consumer accepts the event
frame_done  out  1  one-cycle pulse when key 31 has finished processing

Behaviour:
- Reset (async assert, sync deassert via clk): FSM in IDLE; idx=0; row_sel=0, row_en=0; key_state=0; all debounce counters 0; evt_valid=0, evt_key=0, evt_press=0; frame_done=0; synchronizer flops 0.
- key_in passes through a 2-flop synchronizer. Only the synchronized value (ks) is used.
- row_sel always equals idx. row_en=1 only in SELECT and SAMPLE.
- FSM states:
  - IDLE: if scan_en=1, go to SELECT and clear the settle counter.
  - SELECT: settle counter counts up. After SETTLE_CYCLES cycles in SELECT, go to SAMPLE.
  - SAMPLE: one cycle. Capture ks for key idx and update its debounce counter cnt[idx], which is 3 bits:
    - If ks==key_state[idx]: cnt=0.
    - Else if cnt+1==DEBOUNCE_SCANS: toggle key_state[idx], set cnt=0, load evt_key=idx and evt_press=ks, and go to EMIT.
    - Else: cnt=cnt+1.
    - With no event, go to ADV.
  - EMIT: evt_valid=1. evt_key and evt_press stay stable until the cycle in which evt_valid && evt_ready. In that cycle go to ADV; evt_valid drops on the next cycle. Scanning stalls indefinitely while evt_ready=0. No events are dropped and there is no queue.
  - ADV: one cycle. idx=idx+1, wrapping 31 to 0. frame_done=1 in this cycle iff the old idx was 31. Next state is SELECT if scan_en=1, else IDLE.
- A key slot with no event takes SETTLE_CYCLES+2 cycles. A full frame takes 32*(SETTLE_CYCLES+2) cycles; with defaults that is 6 per key and 192 per frame.
- scan_en deasserted mid-slot: the current slot finishes through SAMPLE, and EMIT if taken, then ADV. The FSM then parks in IDLE with idx advanced. Re-asserting scan_en resumes from that idx.
- evt_ready may be high while evt_valid=0; this has no effect.
- Reset asserted mid-operation, including during EMIT, returns every output to its reset value immediately. No event is produced afterward for the aborted slot.
- key_state changes only in SAMPLE. It updates on the same edge that sets up EMIT, so key_state already reflects the change while evt_valid=1.

Decomposition:
- piano_pkg: NUM_KEYS=32, KEY_IDX_W=5, and the enum scan_state_t {IDLE, SELECT, SAMPLE, EMIT, ADV}.
- Sub-module key_debounce_cell, instantiated 32 times via generate.
  - Inputs: clk, reset_n, update (SAMPLE && idx==k), ks.
  - Outputs: state, toggle.
  - Holds cnt and key_state for one key.
- The top level holds the FSM, idx, settle counter, synchronizer and event registers.

Test Plan:
- Reset then scan_en=1 with key_in=0: row_sel steps 0,1,...,31,0. row_en is high for 5 of every 6 cycles. frame_done pulses every 192 cycles. No evt_valid. key_state=0.
- Key 7 held pressed with evt_ready=1: evt_valid rises in the 3rd frame, with evt_key=7, evt_press=1, key_state[7]=1. Releasing key 7 gives evt_press=0 three frames later.
- Key 12 glitch pressed for 2 frames then released: no event, and key_state[12] stays 0.
- Keys 3 and 20 pressed with evt_ready=0: evt_valid holds evt_key=3 and row_sel holds at 3 with no frame_done. Raising evt_ready for one cycle lets the scan proceed; key 20's event follows later in the frame.
- scan_en dropped while idx=10 is in SELECT: the slot completes, the FSM idles with row_sel=11 and row_en=0. Re-enabling resumes at 11.
- reset_n pulsed low during EMIT for key 5: evt_valid=0, key_state=0 and row_sel=0 immediately. After release, no event is produced until a new debounced press.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared constants and the scan sequencer state type for the key scanner.
package piano_pkg;

  localparam int NUM_KEYS  = 32;
  localparam int KEY_IDX_W = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    SAMPLE = 3'd2,
    EMIT   = 3'd3,
    ADV    = 3'd4
  } scan_state_t;

endpackage

// File: rtl/key_scan_ctrl_if.sv
// Key event channel from the scanner to the note logic.
//
// Handshake: the master raises evt_valid with evt_key/evt_press and holds
// all three stable until a cycle in which evt_valid && evt_ready; that clock
// edge transfers the event. evt_ready while evt_valid is low has no effect.
interface key_scan_ctrl_if;
  import piano_pkg::*;

  logic                 evt_valid;
  logic [KEY_IDX_W-1:0] evt_key;
  logic                 evt_press;
  logic                 evt_ready;

  modport master (output evt_valid, output evt_key, output evt_press, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_press, output evt_ready);

endinterface

// File: rtl/key_debounce_cell.sv
// Per-key debouncer: holds the debounced state and a run-length count of
// consecutive samples that disagree with it.
module key_debounce_cell #(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic update,
  input  logic ks,
  output logic state,
  output logic toggle
);

  localparam logic [2:0] CNT_LAST = 3'(DEBOUNCE_SCANS - 1);

  logic [2:0] cnt;

  // The sample about to be taken completes a disagreeing run, so state flips on this edge.
  assign toggle = update && (ks != state) && (cnt == CNT_LAST);

  // Track disagreeing samples; flip state once the run is long enough.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= 3'd0;
      state <= 1'b0;
    end else if (update) begin
      if (ks == state) begin
        cnt <= 3'd0;
      end else if (cnt == CNT_LAST) begin
        state <= ~state;
        cnt   <= 3'd0;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// Key matrix scanner: walks the 5-to-32 select decoder over every key, lets
// the sense line settle, samples it through a synchronizer, debounces each
// key and reports every debounced press/release as one event.
module key_scan_ctrl
  import piano_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 scan_en,
  input  logic                 key_in,
  output logic [KEY_IDX_W-1:0] row_sel,
  output logic                 row_en,
  output logic [NUM_KEYS-1:0]  key_state,
  output logic                 frame_done,
  key_scan_ctrl_if.master      evt,
  output scan_state_t          state_dbg
);

  localparam logic [3:0]           SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [KEY_IDX_W-1:0] IDX_LAST    = KEY_IDX_W'(NUM_KEYS - 1);

  scan_state_t          state;
  logic [KEY_IDX_W-1:0] idx;
  logic [3:0]           settle_cnt;
  logic                 sync1;
  logic                 ks;
  logic [NUM_KEYS-1:0]  toggle;
  logic                 evt_valid_q;
  logic [KEY_IDX_W-1:0] evt_key_q;
  logic                 evt_press_q;

  assign row_sel       = idx;
  assign row_en        = (state == SELECT) || (state == SAMPLE);
  assign state_dbg     = state;
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_key   = evt_key_q;
  assign evt.evt_press = evt_press_q;

  // Two-flop synchronizer for the asynchronous sense line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      ks    <= 1'b0;
    end else begin
      sync1 <= key_in;
      ks    <= sync1;
    end
  end

  // One debouncer per key; only the currently selected key updates, in SAMPLE.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_cell
    key_debounce_cell #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_cell (
      .clk    (clk),
      .reset_n(reset_n),
      .update ((state == SAMPLE) && (idx == KEY_IDX_W'(k))),
      .ks     (ks),
      .state  (key_state[k]),
      .toggle (toggle[k])
    );
  end

  // Scan sequencer: select, settle, sample, optionally emit, advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      settle_cnt  <= 4'd0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_press_q <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_en) begin
            state      <= SELECT;
            settle_cnt <= 4'd0;
          end
        end
        SELECT: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          if (|toggle) begin
            evt_valid_q <= 1'b1;
            evt_key_q   <= idx;
            evt_press_q <= ks;
            state       <= EMIT;
          end else begin
            state      <= ADV;
            frame_done <= (idx == IDX_LAST);
          end
        end
        EMIT: begin
          // The scan stalls here until the consumer takes the event.
          if (evt.evt_ready) begin
            evt_valid_q <= 1'b0;
            state       <= ADV;
            frame_done  <= (idx == IDX_LAST);
          end
        end
        ADV: begin
          idx <= idx + KEY_IDX_W'(1);
          if (scan_en) begin
            state      <= SELECT;
            settle_cnt <= 4'd0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
